// File: rtl/bcd_convert_seq_pkg.sv
// rtl/bcd_convert_seq_pkg.sv - shared types and digit codes for the BCD display path
//
// Purpose: FSM state encoding for bcd_convert_seq and the special digit codes
// that the seven-segment decoders also understand.
// Ports: none (package).
package bcd_convert_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decoder shows a lone middle segment for MINUS_CODE; BLANK_CODE falls
  // into the decoder's default branch and lights nothing.
  localparam logic [3:0] MINUS_CODE = 4'd10;
  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - shift-add-3 correction cell for one BCD digit
//
// Purpose: combinational "if digit >= 5 then add 3" step, applied to every
// accumulator digit before each left shift.
// Ports:
//   digit    in  4 : current accumulator digit
//   adjusted out 4 : corrected digit (4-bit add, carry discarded)
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// rtl/bcd_convert_seq.sv - sequential binary-to-BCD converter (double dabble)
//
// Purpose: converts the W-bit result word into DIGITS decimal digit codes for
// the HEX displays, one shift-add-3 iteration per clock.
// Optional feature macro: BCD_SIGN_EN (sign-magnitude input; top digit shows
// minus or blank, remaining DIGITS-1 digits numeric).
// Ports:
//   CLOCK_50 in  1          : clock, rising edge
//   RESET    in  1          : synchronous active-high reset
//   start    in  1          : conversion request, honoured only in IDLE
//   bin_in   in  W          : value captured when start is accepted
//   busy     out 1          : conversion in progress (SHIFT state)
//   done     out 1          : one-cycle pulse after bcd_out is updated
//   bcd_out  out 4*DIGITS   : held digit codes, units in bits [3:0]
module bcd_convert_seq
  import bcd_convert_seq_pkg::*;
#(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

`ifdef BCD_SIGN_EN
  localparam int SIGN_BITS = 1;
`else
  localparam int SIGN_BITS = 0;
`endif

  localparam int MW = W - SIGN_BITS;       // magnitude width = iteration count
  localparam int CD = DIGITS - SIGN_BITS;  // digits produced by the loop
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(MW - 1);

  state_t state, state_next;
  logic   load, step, finish;

  logic [MW-1:0]    sr, sr_next;
  logic [4*CD-1:0]  acc, acc_adj, acc_next;
  logic [4*CD+MW-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic [4*DIGITS-1:0] bcd_final;

  for (genvar g = 0; g < CD; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  // Adjusted accumulator and shift register move left as one word; the
  // accumulator's top bit cannot be set for in-range inputs, so it is dropped.
  assign shifted  = {acc_adj[4*CD-2:0], sr, 1'b0};
  assign acc_next = shifted[4*CD+MW-1:MW];
  assign sr_next  = shifted[MW-1:0];

`ifdef BCD_SIGN_EN
  logic sign_q, nz_q;
  // Negative zero is shown as blank, not minus.
  assign bcd_final = {(sign_q && nz_q) ? MINUS_CODE : BLANK_CODE, acc_next};
`else
  assign bcd_final = acc_next;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      bcd_out <= '0;
`ifdef BCD_SIGN_EN
      sign_q  <= 1'b0;
      nz_q    <= 1'b0;
`endif
    end else begin
      if (load) begin
        sr  <= bin_in[MW-1:0];
        acc <= '0;
        cnt <= '0;
`ifdef BCD_SIGN_EN
        sign_q <= bin_in[W-1];
        nz_q   <= |bin_in[MW-1:0];
`endif
      end else if (step) begin
        sr  <= sr_next;
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      // Only the final iteration's result reaches the display register.
      if (finish) bcd_out <= bcd_final;
    end
  end

endmodule
